lsu_data_port: RTL and testbench



---
 rtl/lsu_data_port.sv | 226 ++++++++++++++++++++++
 tb/tb_lsu_data_port.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_data_port.sv
// lsu_data_port: load/store unit data-side port for the single-cycle core.
// Accepts one request at a time, drives the data-RAM bus (req/gnt, then
// rvalid for loads), and returns extended load data with a one-cycle pulse.
//
// Ports:
//   clk, rst_n            core clock, synchronous active-low reset
//   req_*                 request from core (valid/ready handshake)
//   resp_valid/rdata/err  one-cycle completion pulse to write-back
//   mem_*                 data-RAM bus (mem_req held until mem_gnt)
//
// Optional: define LSU_TIMEOUT_EN to enable a watchdog that terminates an
// access with an error after TIMEOUT_CYCLES cycles in ACCESS/WAIT_R.
module lsu_data_port #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
    $error("lsu_data_port: DATA_WIDTH must be 32 and TIMEOUT_CYCLES 1..255");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT_R, RESP} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [1:0]              off_q, off_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [3:0]              mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0]   TO_LIM = 8'(TIMEOUT_CYCLES);
  logic [7:0]              cnt_q, cnt_d;
`endif

  // Request decode (combinational on the live request fields)
  logic                    misaligned;
  logic [3:0]              be_calc;
  logic [DATA_WIDTH-1:0]   wd_calc;
  logic [DATA_WIDTH-1:0]   lane;
  logic [DATA_WIDTH-1:0]   ld_ext;

  always_comb begin
    misaligned = 1'b0;
    be_calc    = 4'b1111;
    wd_calc    = req_wdata;
    case (req_size)
      2'b00: begin
        be_calc = 4'b0001 << req_addr[1:0];
        wd_calc = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = req_addr[0];
        be_calc    = 4'b0011 << req_addr[1:0];
        wd_calc    = {2{req_wdata[15:0]}};
      end
      2'b10: misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Load lane select uses the latched byte offset; bus word is shifted so
  // the addressed byte lands in bits [7:0].
  always_comb begin
    lane   = mem_rdata >> {off_q, 3'b000};
    ld_ext = mem_rdata;
    case (size_q)
      2'b00:   ld_ext = {{(DATA_WIDTH-8){~uns_q & lane[7]}}, lane[7:0]};
      2'b01:   ld_ext = {{(DATA_WIDTH-16){~uns_q & lane[15]}}, lane[15:0]};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
`ifdef LSU_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          size_d = req_size;
          uns_d  = req_unsigned;
          off_d  = req_addr[1:0];
          if (misaligned) begin
            // Rejected without touching the RAM bus
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d     = ACCESS;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_be_d    = be_calc;
            mem_addr_d  = {req_addr[DATA_WIDTH-1:2], 2'b00};
            mem_wdata_d = wd_calc;
`ifdef LSU_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end
        end
      end
      ACCESS: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (mem_we_q) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
          end else begin
            state_d = WAIT_R;
          end
        end
      end
      WAIT_R: begin
        if (mem_rvalid) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = ld_ext;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef LSU_TIMEOUT_EN
    // Count only cycles that did not complete; a completion in the final
    // cycle still wins over the timeout.
    if ((state_q == ACCESS || state_q == WAIT_R) && state_d == state_q) begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_d == TO_LIM) begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
        resp_rdata_d = '0;
        mem_req_d    = 1'b0;
        mem_we_d     = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      off_q        <= 2'b00;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'b0000;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  // Ready is the only combinational output; forced low while reset is held
  assign req_ready  = rst_n && (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_be     = mem_be_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_data_port.sv
// Self-checking bench for lsu_data_port: directed vector table, hand-written
// reset/stall sequences and randomized requests against a byte-level model.
module tb_lsu_data_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int total = 0;
  int bad   = 0;

  lsu_data_port dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, wdata, rdata;
    int          gw, rw;
    logic        err;
    logic [31:0] rd;
    logic [3:0]  be;
    logic [31:0] wd;
    int          lat;
  } vec_t;

  // Byte-level reference: width in bytes, alignment by modulo, lanes by
  // arithmetic shifting/masking.
  task automatic model(input vec_t v, output vec_t e);
    int nb;
    longint sh, mask, val;
    e = v;
    nb = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
    e.err = (v.size == 2'd3) || ((v.addr % nb) != 0);
    e.be  = 4'(((1 << nb) - 1) << v.addr[1:0]);
    for (int i = 0; i < 4; i++) e.wd[8*i +: 8] = v.wdata[8*(i % nb) +: 8];
    sh   = longint'(v.rdata) >> (8 * v.addr[1:0]);
    mask = (longint'(1) << (8 * nb)) - 1;
    val  = sh & mask;
    if (!v.uns && val[8*nb-1]) val = val | (~mask);
    e.rd = 32'(val);
    if (e.err) begin e.rd = '0; e.lat = 1; end
    else if (v.we) begin e.rd = '0; e.lat = v.gw + 2; end
    else e.lat = v.gw + v.rw + 3;
  endtask

  // Issue one request starting just after a clock edge, act as the RAM,
  // and observe the bus and the response.
  task automatic run_req(input vec_t v, input bit spur,
                         output int lat, output logic [31:0] o_rd, output logic o_err,
                         output logic [3:0] o_be, output logic [31:0] o_ma, o_wd,
                         output logic o_we, output int req_cyc, output bit stable,
                         output bit rdy_seen);
    int waited, rv_cnt;
    lat = -1; req_cyc = 0; stable = 1; rdy_seen = 0; waited = 0; rv_cnt = -1;
    o_rd = '0; o_err = 0; o_be = '0; o_ma = '0; o_wd = '0; o_we = 0;
    chk("accept_ready", {31'b0, req_ready}, 32'd1);
    req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hDEAD_BEEF;
      if (rv_cnt == 0) begin mem_rvalid = 1'b1; mem_rdata = v.rdata; rv_cnt = -1; end
      else if (rv_cnt > 0) rv_cnt--;
      if (req_ready) rdy_seen = 1;
      if (mem_req) begin
        if (req_cyc == 0) begin
          o_be = mem_be; o_ma = mem_addr; o_wd = mem_wdata; o_we = mem_we;
        end else if (mem_be !== o_be || mem_addr !== o_ma || mem_wdata !== o_wd || mem_we !== o_we)
          stable = 0;
        req_cyc++;
        if (waited >= v.gw) begin
          mem_gnt = 1'b1;
          if (!v.we) rv_cnt = v.rw;
        end else waited++;
        // Bogus read data while in ACCESS (including the gnt cycle)
        if (spur) begin mem_rvalid = 1'b1; mem_rdata = 32'h5A5A_5A5A; end
      end
      if (resp_valid) begin lat = c; o_rd = resp_rdata; o_err = resp_err; end
      @(posedge clk); #1;
      if (lat >= 0) break;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic check_vec(input string tag, input vec_t v, input vec_t e, input bit spur);
    int lat, rc; logic [31:0] rd, ma, wd; logic err, we; logic [3:0] be; bit st, rs;
    run_req(v, spur, lat, rd, err, be, ma, wd, we, rc, st, rs);
    chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
    chk({tag, "_err"}, {31'b0, err}, {31'b0, e.err});
    chk({tag, "_rdata"}, rd, e.rd);
    chk({tag, "_ready_busy"}, {31'b0, rs}, 32'd0);
    if (e.err) chk({tag, "_no_memreq"}, 32'(rc), 32'd0);
    else begin
      chk({tag, "_be"}, {28'b0, be}, {28'b0, e.be});
      chk({tag, "_maddr"}, ma, {v.addr[31:2], 2'b00});
      chk({tag, "_wdata"}, wd, e.wd);
      chk({tag, "_we"}, {31'b0, we}, {31'b0, v.we});
      chk({tag, "_req_cycles"}, 32'(rc), 32'(v.gw + 1));
      chk({tag, "_stable"}, {31'b0, st}, 32'd1);
    end
  endtask

  vec_t tbl [10];

  initial begin
    vec_t v, e;
    bit seen;

    tbl[0] = '{1'b1, 2'd0, 1'b0, 32'h1003, 32'h000000A5, 32'h0, 0, 0, 1'b0, 32'h0, 4'b1000, 32'hA5A5A5A5, 2};
    tbl[1] = '{1'b0, 2'd1, 1'b0, 32'h2002, 32'h0, 32'h80011234, 0, 0, 1'b0, 32'hFFFF8001, 4'b1100, 32'h0, 3};
    tbl[2] = '{1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 32'h80011234, 0, 0, 1'b0, 32'h00008001, 4'b1100, 32'h0, 3};
    tbl[3] = '{1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 32'h0, 0, 0, 1'b1, 32'h0, 4'b0000, 32'h0, 1};
    tbl[4] = '{1'b1, 2'd3, 1'b0, 32'h4000, 32'h11, 32'h0, 0, 0, 1'b1, 32'h0, 4'b0000, 32'h0, 1};
    tbl[5] = '{1'b0, 2'd0, 1'b0, 32'h5001, 32'h0, 32'h00008000, 0, 0, 1'b0, 32'hFFFFFF80, 4'b0010, 32'h0, 3};
    tbl[6] = '{1'b0, 2'd0, 1'b1, 32'h5003, 32'h0, 32'h7F000000, 1, 0, 1'b0, 32'h0000007F, 4'b1000, 32'h0, 4};
    tbl[7] = '{1'b1, 2'd1, 1'b0, 32'h6002, 32'h1234BEEF, 32'h0, 0, 2, 1'b0, 32'h0, 4'b1100, 32'hBEEFBEEF, 2};
    tbl[8] = '{1'b0, 2'd2, 1'b0, 32'h7000, 32'h0, 32'hCAFEF00D, 2, 1, 1'b0, 32'hCAFEF00D, 4'b1111, 32'h0, 6};
    tbl[9] = '{1'b1, 2'd1, 1'b0, 32'h6001, 32'h1, 32'h0, 0, 0, 1'b1, 32'h0, 4'b0000, 32'h0, 1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 10; i++) check_vec($sformatf("vec%0d", i), tbl[i], tbl[i], 1'b0);

    // Load word, gnt withheld 3 cycles, bogus rvalid during ACCESS
    v = '{1'b0, 2'd2, 1'b0, 32'h0000_9004, 32'h0, 32'h1357_9BDF, 3, 0, 1'b0, 32'h0, 4'b0, 32'h0, 0};
    model(v, e);
    check_vec("stall", v, e, 1'b1);

    // Reset while waiting for read data, then a late rvalid
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h8000; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mr_access_req", {31'b0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    chk("mr_waitr_req", {31'b0, mem_req}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mr_ready_in_rst", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    chk("mr_mem_req", {31'b0, mem_req}, 32'd0);
    chk("mr_mem_be", {28'b0, mem_be}, 32'd0);
    chk("mr_resp_err", {31'b0, resp_err}, 32'd0);
    chk("mr_resp_rdata", resp_rdata, 32'd0);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (resp_valid) seen = 1;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
    end
    chk("mr_no_resp", {31'b0, seen}, 32'd0);
    v = '{1'b0, 2'd0, 1'b0, 32'h0000_8002, 32'h0, 32'h00FE_0000, 0, 0, 1'b0, 32'h0, 4'b0, 32'h0, 0};
    model(v, e);
    check_vec("after_rst", v, e, 1'b0);

`ifdef LSU_TIMEOUT_EN
    begin
      int lat, rc; logic [31:0] rd, ma, wd; logic err, we; logic [3:0] be; bit st, rs;
      v = '{1'b0, 2'd2, 1'b0, 32'h0000_A000, 32'h0, 32'h0, 1000, 0, 1'b0, 32'h0, 4'b0, 32'h0, 0};
      run_req(v, 1'b0, lat, rd, err, be, ma, wd, we, rc, st, rs);
      chk("to_lat", 32'(lat), 32'd17);
      chk("to_err", {31'b0, err}, 32'd1);
      chk("to_rdata", rd, 32'd0);
      chk("to_req_cycles", 32'(rc), 32'd16);
      mem_gnt = 1'b1; mem_rvalid = 1'b1;
      seen = 0;
      for (int k = 0; k < 3; k++) begin
        if (resp_valid || mem_req) seen = 1;
        @(posedge clk); #1;
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      chk("to_late_ignored", {31'b0, seen}, 32'd0);
    end
`endif

    // Randomized requests against the model
    for (int n = 0; n < 40; n++) begin
      bit spur;
      v.we    = 1'($urandom_range(0, 1));
      v.size  = 2'($urandom_range(0, 3));
      v.uns   = 1'($urandom_range(0, 1));
      v.addr  = $urandom;
      v.wdata = $urandom;
      v.rdata = $urandom;
      v.gw    = int'($urandom_range(0, 3));
      v.rw    = int'($urandom_range(0, 2));
      spur    = 1'($urandom_range(0, 1));
      model(v, e);
      check_vec($sformatf("rnd%0d", n), v, e, spur);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
